// File: rtl/seq_pkg.sv
// seq_pkg: shared defaults and helpers (length clamp, low-bit compare mask) for the sequence detector
package seq_pkg;
  localparam int SEQ_MAX_LEN = 8;
  localparam int SEQ_CNT_W = 8;
  function automatic int clamp_len(input int pat_len, input int max_len);
    return pat_len > max_len ? max_len : pat_len;
  endfunction
  function automatic logic [63:0] len_mask(input int l);
    return l >= 64 ? '1 : (64'd1 << l) - 64'd1;
  endfunction
endpackage

// File: rtl/seq_hist_shift.sv
// seq_hist_shift: bit history + fill counter; ports clk/rst, shift (valid bit), restart (drop history on shift), clear, in -> next, fill_next
module seq_hist_shift import seq_pkg::*; #(
  parameter int MAX_LEN = SEQ_MAX_LEN,
  parameter int FILL_W = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               shift,
  input  logic               restart,
  input  logic               clear,
  input  logic               in,
  output logic [MAX_LEN-1:0] next,
  output logic [FILL_W-1:0]  fill_next
);
  logic [MAX_LEN-1:0] hist;
  logic [FILL_W-1:0] fill;
  assign next = {hist[MAX_LEN-2:0], in};
  assign fill_next = fill == FILL_W'(MAX_LEN) ? fill : fill + FILL_W'(1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      hist <= '0;
      fill <= '0;
    end else if (clear || (shift && restart)) begin
      hist <= '0;
      fill <= '0;
    end else if (shift) begin
      hist <= next;
      fill <= fill_next;
    end
endmodule

// File: rtl/seq_detect_param.sv
// seq_detect_param: programmable serial pattern detector; ports clk/rst, in_valid/in stream, pat/pat_len/overlap config, clear -> out pulse, match_cnt, cnt_sat
module seq_detect_param import seq_pkg::*; #(
  parameter int MAX_LEN = SEQ_MAX_LEN,
  parameter int CNT_W = SEQ_CNT_W,
  localparam int LEN_W = $clog2(MAX_LEN) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               in,
  input  logic [MAX_LEN-1:0] pat,
  input  logic [LEN_W-1:0]   pat_len,
  input  logic               overlap,
  input  logic               clear,
  output logic               out,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               cnt_sat
);
  localparam int FILL_W = $clog2(MAX_LEN + 1);
  logic [MAX_LEN-1:0] next;
  logic [MAX_LEN-1:0] mask;
  logic [FILL_W-1:0] fill_next;
  int l;
  logic hit;
  assign l = clamp_len(int'(pat_len), MAX_LEN);
  assign mask = MAX_LEN'(len_mask(l));
  assign hit = in_valid && !clear && l >= 1 && int'(fill_next) >= l && ((next ^ pat) & mask) == '0;
  assign cnt_sat = &match_cnt;
  seq_hist_shift #(.MAX_LEN(MAX_LEN), .FILL_W(FILL_W)) u_hist (
    .clk(clk),
    .rst(rst),
    .shift(in_valid && !clear),
    .restart(hit && !overlap),
    .clear(clear),
    .in(in),
    .next(next),
    .fill_next(fill_next)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out <= 1'b0;
      match_cnt <= '0;
    end else begin
      out <= hit;
      match_cnt <= clear ? '0 : (hit && !cnt_sat) ? match_cnt + CNT_W'(1) : match_cnt;
    end
endmodule

// File: tb/tb_seq_detect_param.sv
// tb_seq_detect_param: directed checks of the sequence detector with MAX_LEN=8, CNT_W=4
module tb_seq_detect_param;
  logic clk = 0, rst = 1, in_valid = 0, in = 0, overlap = 1, clear = 0;
  logic [7:0] pat = 8'b1011;
  logic [3:0] pat_len = 4'd4;
  logic out, cnt_sat;
  logic [3:0] match_cnt;
  int vectors = 0, errs = 0;

  seq_detect_param #(.MAX_LEN(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(in), .pat(pat), .pat_len(pat_len),
    .overlap(overlap), .clear(clear), .out(out), .match_cnt(match_cnt), .cnt_sat(cnt_sat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic b, input logic exp_out, input string tag);
    in_valid = v;
    in = b;
    @(posedge clk);
    #1;
    chk(tag, 32'(out), 32'(exp_out));
    in_valid = 0;
  endtask

  task automatic do_clear();
    clear = 1;
    in_valid = 0;
    @(posedge clk);
    #1;
    clear = 0;
    chk("clear_out", 32'(out), 0);
    chk("clear_cnt", 32'(match_cnt), 0);
  endtask

  initial begin
    logic [6:0] s7;
    logic [6:0] e7;
    logic [7:0] s8;
    #12;
    chk("rst_out", 32'(out), 0);
    chk("rst_cnt", 32'(match_cnt), 0);
    chk("rst_sat", 32'(cnt_sat), 0);
    rst = 0;
    @(posedge clk);
    #1;
    // overlap mode: 1011011 matches after bits 4 and 7
    s7 = 7'b1011011;
    e7 = 7'b0001001;
    for (int i = 6; i >= 0; i--) step(1, s7[i], e7[i], "ovl_out");
    chk("ovl_cnt", 32'(match_cnt), 2);
    // async reset between edges with a nonzero counter
    step(1, 1, 0, "ar_pre");
    step(1, 0, 0, "ar_pre");
    step(1, 1, 0, "ar_pre");
    rst = 1;
    #1;
    chk("ar_out", 32'(out), 0);
    chk("ar_cnt", 32'(match_cnt), 0);
    chk("ar_sat", 32'(cnt_sat), 0);
    #2;
    rst = 0;
    step(1, 1, 0, "ar_post");
    step(1, 1, 0, "ar_post");
    chk("ar_post_cnt", 32'(match_cnt), 0);
    // non-overlap: history restarts after the first match
    overlap = 0;
    do_clear();
    e7 = 7'b0001000;
    for (int i = 6; i >= 0; i--) step(1, s7[i], e7[i], "novl_out");
    chk("novl_cnt", 32'(match_cnt), 1);
    // valid gaps with in toggling while invalid
    overlap = 1;
    pat = 8'b101;
    pat_len = 4'd3;
    do_clear();
    step(1, 1, 0, "gap_v1");
    step(0, 0, 0, "gap_idle");
    step(0, 1, 0, "gap_idle");
    step(1, 0, 0, "gap_v2");
    step(0, 1, 0, "gap_idle");
    step(0, 0, 0, "gap_idle");
    step(1, 1, 1, "gap_v3");
    step(0, 0, 0, "gap_after");
    chk("gap_cnt", 32'(match_cnt), 1);
    // clear on the completing bit suppresses the match
    pat = 8'b1011;
    pat_len = 4'd4;
    do_clear();
    step(1, 1, 0, "clr_pre");
    step(1, 0, 0, "clr_pre");
    step(1, 1, 0, "clr_pre");
    clear = 1;
    step(1, 1, 0, "clr_hit_out");
    clear = 0;
    chk("clr_hit_cnt", 32'(match_cnt), 0);
    // pat_len=0 never matches, even when the masked compare is trivially equal
    pat = 8'h00;
    pat_len = 4'd0;
    do_clear();
    for (int i = 0; i < 10; i++) step(1, 0, 0, "len0_out");
    chk("len0_cnt", 32'(match_cnt), 0);
    // pat_len above MAX_LEN clamps to 8
    pat = 8'b10110011;
    pat_len = 4'd11;
    do_clear();
    s8 = 8'b10110011;
    for (int i = 7; i >= 0; i--) step(1, s8[i], i == 0, "clamp_out");
    chk("clamp_cnt", 32'(match_cnt), 1);
    // saturation with L=1 right after clear
    pat = 8'h01;
    pat_len = 4'd1;
    do_clear();
    for (int i = 0; i < 20; i++) begin
      step(1, 1, 1, "sat_out");
      chk("sat_cnt", 32'(match_cnt), i >= 14 ? 15 : i + 1);
      chk("sat_flag", 32'(cnt_sat), i >= 14 ? 1 : 0);
    end
    step(0, 1, 0, "sat_idle");
    chk("sat_hold", 32'(match_cnt), 15);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
